// File: rtl/vdp18_hv_timing.sv
// rtl/vdp18_hv_timing.sv - VDP raster H/V position counters with sync, blank and frame interrupt decode.
// Optional VDP18_HV_LATCH_EN adds hv_latch_i / hlatch_o / vlatch_o position capture.
module vdp18_hv_timing #(
  parameter int H_TOTAL      = 342,
  parameter int H_ACTIVE     = 256,
  parameter int HBLANK_START = 271,
  parameter int HSYNC_START  = 284,
  parameter int HSYNC_END    = 310,
  parameter int HBLANK_END   = 329,
  parameter int V_ACTIVE     = 192,
  parameter int V_TOTAL_NTSC = 262,
  parameter int V_TOTAL_PAL  = 313,
  parameter int VBLANK_NTSC  = 216,
  parameter int VBLANK_PAL   = 240,
  parameter int VTOP_NTSC    = 27,
  parameter int VTOP_PAL     = 51,
  parameter int VSYNC_OFS    = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clk_en_5m37_i,
  input  logic       pal_i,
  input  logic       int_clr_i,
`ifdef VDP18_HV_LATCH_EN
  input  logic       hv_latch_i,
  output logic [8:0] hlatch_o,
  output logic [8:0] vlatch_o,
`endif
  output logic [8:0] hcnt_o,
  output logic [8:0] vcnt_o,
  output logic       hsync_n_o,
  output logic       vsync_n_o,
  output logic       blank_o,
  output logic       active_o,
  output logic       frame_start_o,
  output logic       int_flag_o
);

  localparam logic [8:0] L_H_LAST    = 9'(H_TOTAL - 1);
  localparam logic [8:0] L_H_ACT     = 9'(H_ACTIVE);
  localparam logic [8:0] L_HB_S      = 9'(HBLANK_START);
  localparam logic [8:0] L_HB_E      = 9'(HBLANK_END);
  localparam logic [8:0] L_HS_S      = 9'(HSYNC_START);
  localparam logic [8:0] L_HS_E      = 9'(HSYNC_END);
  localparam logic [8:0] L_V_ACT     = 9'(V_ACTIVE);
  localparam logic [8:0] L_VT_LAST_N = 9'(V_TOTAL_NTSC - 1);
  localparam logic [8:0] L_VT_LAST_P = 9'(V_TOTAL_PAL - 1);
  localparam logic [8:0] L_VB_S_N    = 9'(VBLANK_NTSC);
  localparam logic [8:0] L_VB_S_P    = 9'(VBLANK_PAL);
  localparam logic [8:0] L_VB_E_N    = 9'(V_TOTAL_NTSC - VTOP_NTSC);
  localparam logic [8:0] L_VB_E_P    = 9'(V_TOTAL_PAL - VTOP_PAL);
  localparam logic [8:0] L_VS_S_N    = 9'(VBLANK_NTSC + VSYNC_OFS);
  localparam logic [8:0] L_VS_S_P    = 9'(VBLANK_PAL + VSYNC_OFS);
  localparam logic [8:0] L_VS_E_N    = 9'(VBLANK_NTSC + VSYNC_OFS + 3);
  localparam logic [8:0] L_VS_E_P    = 9'(VBLANK_PAL + VSYNC_OFS + 3);

  logic [8:0] r_hcnt;
  logic [8:0] r_vcnt;
  logic       r_pal_q;
  logic       r_int_flag;

  logic [8:0] w_vt_last;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [8:0] w_hcnt_nxt;
  logic [8:0] w_vcnt_nxt;
  logic [8:0] w_vb_s;
  logic [8:0] w_vb_e;
  logic [8:0] w_vs_s;
  logic [8:0] w_vs_e;
  logic       w_hblank;
  logic       w_vblank;

  // Frame length follows the standard latched at the last frame wrap, never pal_i directly.
  assign w_vt_last  = r_pal_q ? L_VT_LAST_P : L_VT_LAST_N;
  assign w_h_wrap   = (r_hcnt == L_H_LAST);
  assign w_v_wrap   = w_h_wrap && (r_vcnt == w_vt_last);
  assign w_hcnt_nxt = w_h_wrap ? 9'd0 : r_hcnt + 9'd1;
  assign w_vcnt_nxt = w_v_wrap ? 9'd0 : (w_h_wrap ? r_vcnt + 9'd1 : r_vcnt);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_hcnt  <= 9'd0;
      r_vcnt  <= 9'd0;
      r_pal_q <= 1'b0;
    end else if (clk_en_5m37_i) begin
      r_hcnt <= w_hcnt_nxt;
      r_vcnt <= w_vcnt_nxt;
      if (w_v_wrap) r_pal_q <= pal_i;
    end
  end

  // Set has priority so a status read racing the interrupt cannot lose it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_int_flag <= 1'b0;
    end else if (clk_en_5m37_i && w_h_wrap && (w_vcnt_nxt == L_V_ACT)) begin
      r_int_flag <= 1'b1;
    end else if (int_clr_i) begin
      r_int_flag <= 1'b0;
    end
  end

  assign w_vb_s   = r_pal_q ? L_VB_S_P : L_VB_S_N;
  assign w_vb_e   = r_pal_q ? L_VB_E_P : L_VB_E_N;
  assign w_vs_s   = r_pal_q ? L_VS_S_P : L_VS_S_N;
  assign w_vs_e   = r_pal_q ? L_VS_E_P : L_VS_E_N;
  assign w_hblank = (r_hcnt >= L_HB_S) && (r_hcnt < L_HB_E);
  assign w_vblank = (r_vcnt >= w_vb_s) && (r_vcnt < w_vb_e);

  assign hcnt_o        = r_hcnt;
  assign vcnt_o        = r_vcnt;
  assign hsync_n_o     = !((r_hcnt >= L_HS_S) && (r_hcnt < L_HS_E));
  assign vsync_n_o     = !((r_vcnt >= w_vs_s) && (r_vcnt < w_vs_e));
  assign blank_o       = w_hblank || w_vblank;
  assign active_o      = (r_hcnt < L_H_ACT) && (r_vcnt < L_V_ACT);
  assign frame_start_o = clk_en_5m37_i && w_v_wrap;
  assign int_flag_o    = r_int_flag;

`ifdef VDP18_HV_LATCH_EN
  logic [8:0] r_hlatch;
  logic [8:0] r_vlatch;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_hlatch <= 9'd0;
      r_vlatch <= 9'd0;
    end else if (hv_latch_i) begin
      r_hlatch <= r_hcnt;
      r_vlatch <= r_vcnt;
    end
  end

  assign hlatch_o = r_hlatch;
  assign vlatch_o = r_vlatch;
`endif

endmodule

// File: tb/tb_vdp18_hv_timing.sv
// tb/tb_vdp18_hv_timing.sv - scoreboard bench for vdp18_hv_timing; full-size and vertically shortened instances.
// Latch ports are exercised when VDP18_HV_LATCH_EN is defined.
module tb_vdp18_hv_timing;
  localparam int H = 342;

  typedef struct packed {
    int vact; int vtn; int vtp; int vbn; int vbp; int vtopn; int vtopp; int vso;
  } cfg_t;
  typedef struct packed { int h; int v; int pal; int flag; int hl; int vl; } mst_t;
  typedef struct packed {
    logic [8:0] h; logic [8:0] v;
    logic hs_n; logic vs_n; logic blank; logic active; logic fs; logic flag;
    logic [8:0] hl; logic [8:0] vl;
  } exp_t;

  localparam cfg_t CF = '{vact: 192, vtn: 262, vtp: 313, vbn: 216, vbp: 240, vtopn: 27, vtopp: 51, vso: 3};
  localparam cfg_t CS = '{vact: 6, vtn: 14, vtp: 17, vbn: 8, vbp: 10, vtopn: 2, vtopp: 3, vso: 1};

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic en = 1'b0, pal = 1'b0, clr = 1'b0, lat = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] f_h, f_v, s_h, s_v, f_hl, f_vl, s_hl, s_vl;
  logic f_hs, f_vs, f_bl, f_ac, f_fs, f_if, s_hs, s_vs, s_bl, s_ac, s_fs, s_if;

  vdp18_hv_timing u_full (
    .clk_i(clk), .reset_i(reset_i), .clk_en_5m37_i(en), .pal_i(pal), .int_clr_i(clr),
`ifdef VDP18_HV_LATCH_EN
    .hv_latch_i(lat), .hlatch_o(f_hl), .vlatch_o(f_vl),
`endif
    .hcnt_o(f_h), .vcnt_o(f_v), .hsync_n_o(f_hs), .vsync_n_o(f_vs), .blank_o(f_bl),
    .active_o(f_ac), .frame_start_o(f_fs), .int_flag_o(f_if)
  );

  vdp18_hv_timing #(
    .V_ACTIVE(6), .V_TOTAL_NTSC(14), .V_TOTAL_PAL(17), .VBLANK_NTSC(8), .VBLANK_PAL(10),
    .VTOP_NTSC(2), .VTOP_PAL(3), .VSYNC_OFS(1)
  ) u_small (
    .clk_i(clk), .reset_i(reset_i), .clk_en_5m37_i(en), .pal_i(pal), .int_clr_i(clr),
`ifdef VDP18_HV_LATCH_EN
    .hv_latch_i(lat), .hlatch_o(s_hl), .vlatch_o(s_vl),
`endif
    .hcnt_o(s_h), .vcnt_o(s_v), .hsync_n_o(s_hs), .vsync_n_o(s_vs), .blank_o(s_bl),
    .active_o(s_ac), .frame_start_o(s_fs), .int_flag_o(s_if)
  );

`ifndef VDP18_HV_LATCH_EN
  assign f_hl = 9'd0; assign f_vl = 9'd0; assign s_hl = 9'd0; assign s_vl = 9'd0;
`endif

  exp_t act_f, act_s;
  assign act_f = {f_h, f_v, f_hs, f_vs, f_bl, f_ac, f_fs, f_if, f_hl, f_vl};
  assign act_s = {s_h, s_v, s_hs, s_vs, s_bl, s_ac, s_fs, s_if, s_hl, s_vl};

  exp_t qf[$], qs[$];
  mst_t sf, ss;
  int n_checks = 0, n_fail = 0;
  bit force_clr = 0;

  function automatic int vtot(cfg_t c, int p);
    return p != 0 ? c.vtp : c.vtn;
  endfunction

  // Expected outputs for the current model position; frame_start depends on this cycle's enable.
  function automatic exp_t predict(cfg_t c, mst_t s, logic e);
    exp_t r;
    int vb, ve, vs;
    vb = s.pal != 0 ? c.vbp : c.vbn;
    ve = vtot(c, s.pal) - (s.pal != 0 ? c.vtopp : c.vtopn);
    vs = vb + c.vso;
    r.h      = 9'(s.h);
    r.v      = 9'(s.v);
    r.hs_n   = !(s.h >= 284 && s.h < 310);
    r.vs_n   = !(s.v >= vs && s.v < vs + 3);
    r.blank  = (s.h >= 271 && s.h < 329) || (s.v >= vb && s.v < ve);
    r.active = (s.h < 256) && (s.v < c.vact);
    r.fs     = e && (s.v * H + s.h == vtot(c, s.pal) * H - 1);
    r.flag   = s.flag != 0;
`ifdef VDP18_HV_LATCH_EN
    r.hl = 9'(s.hl);
    r.vl = 9'(s.vl);
`else
    r.hl = 9'd0;
    r.vl = 9'd0;
`endif
    return r;
  endfunction

  // Position is tracked as a linear pixel index within the frame.
  function automatic mst_t step(cfg_t c, mst_t s, logic e, logic p, logic cl, logic l);
    mst_t r;
    int pos;
    r = s;
    pos = -1;
    if (l) begin r.hl = s.h; r.vl = s.v; end
    if (e) begin
      pos = s.v * H + s.h + 1;
      if (pos == vtot(c, s.pal) * H) begin pos = 0; r.pal = int'(p); end
      r.h = pos % H;
      r.v = pos / H;
    end
    if (pos == c.vact * H) r.flag = 1;
    else if (cl) r.flag = 0;
    return r;
  endfunction

  task automatic run(input logic rst, input logic e, input logic p, input logic c, input logic l);
    logic cc;
    @(posedge clk); #1;
    if (!reset_i) begin
      sf = step(CF, sf, en, pal, clr, lat);
      ss = step(CS, ss, en, pal, clr, lat);
    end
    cc = c;
    if (force_clr && e && (ss.v * H + ss.h + 1 == CS.vact * H)) cc = 1'b1;
    reset_i = rst; en = e; pal = p; clr = cc; lat = l;
    if (rst) begin sf = '0; ss = '0; end
    qf.push_back(predict(CF, sf, en));
    qs.push_back(predict(CS, ss, en));
  endtask

  task automatic check(input string nm, input exp_t a, input exp_t x);
    n_checks++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s t=%0t got h=%0d v=%0d hs_n=%b vs_n=%b blank=%b act=%b fs=%b int=%b hl=%0d vl=%0d required h=%0d v=%0d hs_n=%b vs_n=%b blank=%b act=%b fs=%b int=%b hl=%0d vl=%0d",
               nm, $time, a.h, a.v, a.hs_n, a.vs_n, a.blank, a.active, a.fs, a.flag, a.hl, a.vl,
               x.h, x.v, x.hs_n, x.vs_n, x.blank, x.active, x.fs, x.flag, x.hl, x.vl);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (qf.size() > 0) check("full", act_f, qf.pop_front());
      if (qs.size() > 0) check("small", act_s, qs.pop_front());
    end
  end

  function automatic logic rnd(int n);
    return $urandom_range(0, n - 1) == 0;
  endfunction

  initial begin
    logic p;
    sf = '0; ss = '0;
    repeat (4) run(1, 0, 0, 0, 0);
    repeat (700) run(0, 1, 0, rnd(64), rnd(16));
    for (int i = 0; i < 1000; i++) run(0, logic'(i % 2), 0, rnd(64), rnd(16));
    force_clr = 1;
    repeat (3000) run(0, 1, 0, rnd(64), rnd(16));
    repeat (15000) run(0, 1, 1, rnd(64), rnd(16));
    p = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      if (i % 2000 == 0) p = logic'($urandom_range(0, 1));
      run(0, !rnd(4), p, rnd(64), rnd(16));
    end
    repeat (3) run(1, 1, 0, 0, 0);
    repeat (60) run(0, 1, 0, rnd(8), rnd(4));
    for (int k = 0; k < 10 && (qf.size() > 0 || qs.size() > 0); k++) @(posedge clk);
    if (qf.size() > 0 || qs.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain got %0d pending required 0", qf.size() + qs.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
